// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared defaults and types for the VGA pixel buffer slice.
//   DEF_AXI_DATA_WIDTH  : default width of incoming memory words
//   DEF_FIFO_DEPTH      : default word FIFO depth (power of two, >= 2)
//   DEF_PXL_SLOT_WIDTH  : default bits per packed pixel slot
//   DEF_COLOUR_DEPTH    : default bits per colour channel
//   pxl_t               : packed pixel (red, green, blue)
//   ST_IDLE / ST_ACTIVE : unpacker FSM state encoding
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int DEF_AXI_DATA_WIDTH = 64;
    localparam int DEF_FIFO_DEPTH     = 8;
    localparam int DEF_PXL_SLOT_WIDTH = 16;
    localparam int DEF_COLOUR_DEPTH   = 4;

    typedef struct packed {
        logic [DEF_COLOUR_DEPTH-1:0] red;
        logic [DEF_COLOUR_DEPTH-1:0] green;
        logic [DEF_COLOUR_DEPTH-1:0] blue;
    } pxl_t;

    // Unpacker states: IDLE = no word held, ACTIVE = word held.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/vga_sync_fifo.sv
// -----------------------------------------------------------------------------
// vga_sync_fifo
// Single-clock word FIFO. Pushes into a full FIFO and pops from an empty
// FIFO are ignored. full/empty/level are derived from registered pointers
// only, so a word written this cycle is first visible on the next cycle.
// Ports:
//   clk_i    : clock, rising edge
//   rstn_i   : synchronous active-low reset (empties the FIFO)
//   push_i   : write request, data_i captured when not full
//   data_i   : write data
//   pop_i    : read request, head word removed when not empty
//   data_o   : head word (valid while empty_o is low)
//   full_o   : FIFO holds DEPTH words
//   empty_o  : FIFO holds no words
//   level_o  : number of words held
// -----------------------------------------------------------------------------
module vga_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [LVL_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (level_o == LVL_W'(DEPTH));
    assign empty_o = (level_o == '0);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (rstn_i && push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/vga_pxl_buffer.sv
// -----------------------------------------------------------------------------
// vga_pxl_buffer
// Buffers packed pixel words from the memory read path and unpacks them into
// one pixel per display request.
// Optional feature: define VGA_PXL_BUF_STATS_EN to add underflow_cnt_o, a
// saturating 16-bit count of requests that found no pixel data.
// Ports:
//   aclk_i          : clock, rising edge
//   arstn_i         : synchronous active-low reset
//   wdata_i         : packed pixel word
//   wvalid_i        : wdata_i valid
//   wrdy_o          : buffer can accept a word (!full)
//   pxl_rd_i        : pixel request, one pixel per asserted cycle
//   red_o/green_o/blue_o : registered pixel colour
//   pxl_valid_o     : colour outputs carry real pixel data
//   underflow_o     : sticky, a request found no data
//   level_o         : words in the FIFO (held word excluded)
//   dbg_state_o     : unpacker FSM state (ST_IDLE / ST_ACTIVE)
//   underflow_cnt_o : underflowing request count (VGA_PXL_BUF_STATS_EN only)
// Handshake: a word transfers on a rising edge where wvalid_i && wrdy_o;
// wrdy_o depends only on FIFO state, never on wvalid_i.
// -----------------------------------------------------------------------------
module vga_pxl_buffer
    import vga_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = DEF_AXI_DATA_WIDTH,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int PXL_SLOT_WIDTH = DEF_PXL_SLOT_WIDTH,
    parameter int COLOUR_DEPTH   = DEF_COLOUR_DEPTH
) (
    input  logic                          aclk_i,
    input  logic                          arstn_i,
    input  logic [AXI_DATA_WIDTH-1:0]     wdata_i,
    input  logic                          wvalid_i,
    output logic                          wrdy_o,
    input  logic                          pxl_rd_i,
    output logic [COLOUR_DEPTH-1:0]       red_o,
    output logic [COLOUR_DEPTH-1:0]       green_o,
    output logic [COLOUR_DEPTH-1:0]       blue_o,
    output logic                          pxl_valid_o,
    output logic                          underflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic [0:0]                    dbg_state_o
`ifdef VGA_PXL_BUF_STATS_EN
    ,
    output logic [15:0]                   underflow_cnt_o
`endif
);

    localparam int PXLS_PER_WORD = AXI_DATA_WIDTH / PXL_SLOT_WIDTH;
    localparam int SLOT_W        = (PXLS_PER_WORD > 1) ? $clog2(PXLS_PER_WORD) : 1;

    logic [AXI_DATA_WIDTH-1:0] fifo_rdata;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_pop;

    logic [0:0]                state_q, state_d;
    logic [SLOT_W-1:0]         slot_q, slot_d;
    logic [AXI_DATA_WIDTH-1:0] word_q, word_d;
    logic [COLOUR_DEPTH-1:0]   red_q, red_d;
    logic [COLOUR_DEPTH-1:0]   green_q, green_d;
    logic [COLOUR_DEPTH-1:0]   blue_q, blue_d;
    logic                      valid_q, valid_d;
    logic                      underflow_q, underflow_d;
    logic                      req_underflow;
    int unsigned               slot_base;

    vga_sync_fifo #(
        .WIDTH (AXI_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (aclk_i),
        .rstn_i  (arstn_i),
        .push_i  (wvalid_i),
        .data_i  (wdata_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    assign wrdy_o        = !fifo_full;
    assign req_underflow = pxl_rd_i && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        word_d      = word_q;
        fifo_pop    = 1'b0;
        red_d       = '0;
        green_d     = '0;
        blue_d      = '0;
        valid_d     = 1'b0;
        underflow_d = underflow_q || req_underflow;
        slot_base   = PXL_SLOT_WIDTH * int'(slot_q);

        case (state_q)
            ST_IDLE: begin
                // Loading a word does not consume a pixel.
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    word_d   = fifo_rdata;
                    slot_d   = '0;
                    state_d  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (pxl_rd_i) begin
                    valid_d = 1'b1;
                    red_d   = word_q[slot_base + 2*COLOUR_DEPTH +: COLOUR_DEPTH];
                    green_d = word_q[slot_base + COLOUR_DEPTH +: COLOUR_DEPTH];
                    blue_d  = word_q[slot_base +: COLOUR_DEPTH];
                    if (slot_q == SLOT_W'(PXLS_PER_WORD - 1)) begin
                        slot_d = '0;
                        // Chain straight into the next word so the stream has no gap.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            word_d   = fifo_rdata;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                slot_d  = '0;
            end
        endcase
    end

    always_ff @(posedge aclk_i) begin
        if (!arstn_i) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            word_q      <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            word_q      <= word_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            valid_q     <= valid_d;
            underflow_q <= underflow_d;
        end
    end

    assign red_o       = red_q;
    assign green_o     = green_q;
    assign blue_o      = blue_q;
    assign pxl_valid_o = valid_q;
    assign underflow_o = underflow_q;
    assign dbg_state_o = state_q;

`ifdef VGA_PXL_BUF_STATS_EN
    logic [15:0] uf_cnt_q, uf_cnt_d;

    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if (req_underflow && (uf_cnt_q != 16'hFFFF)) uf_cnt_d = uf_cnt_q + 16'd1;
    end

    always_ff @(posedge aclk_i) begin
        if (!arstn_i) uf_cnt_q <= '0;
        else          uf_cnt_q <= uf_cnt_d;
    end

    assign underflow_cnt_o = uf_cnt_q;
`endif

endmodule
